// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core with Harvard ports: combinational instruction ROM
// and word-wide data RAM. Every instruction retires on one rising edge.
module rv32i_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] r_pc;
  logic [31:0] r_regs [32];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1Idx;
  logic [4:0]  w_rs2Idx;
  logic [2:0]  w_funct3;
  logic        w_alt;
  logic [31:0] w_immI;
  logic [31:0] w_immS;
  logic [31:0] w_immB;
  logic [31:0] w_immU;
  logic [31:0] w_immJ;
  logic [31:0] w_rs1;
  logic [31:0] w_rs2;
  logic [31:0] w_aluB;
  logic [4:0]  w_shamt;
  logic [31:0] w_aluOut;
  logic        w_taken;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_target;
  logic [31:0] w_nextPc;
  logic [31:0] w_rdData;
  logic        w_regWrite;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_rs1Idx = instr[19:15];
  assign w_rs2Idx = instr[24:20];
  assign w_alt    = instr[30];

  assign w_immI = {{20{instr[31]}}, instr[31:20]};
  assign w_immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_immU = {instr[31:12], 12'd0};
  assign w_immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign w_rs1 = (w_rs1Idx == 5'd0) ? 32'd0 : r_regs[w_rs1Idx];
  assign w_rs2 = (w_rs2Idx == 5'd0) ? 32'd0 : r_regs[w_rs2Idx];

  // Register-register and register-immediate ops share one ALU; only OP_REG can subtract.
  always_comb begin
    w_aluB   = (w_opcode == OP_REG) ? w_rs2 : w_immI;
    w_shamt  = w_aluB[4:0];
    w_aluOut = 32'd0;
    case (w_funct3)
      3'd0: w_aluOut = (w_opcode == OP_REG && w_alt) ? (w_rs1 - w_aluB) : (w_rs1 + w_aluB);
      3'd1: w_aluOut = w_rs1 << w_shamt;
      3'd2: w_aluOut = {31'd0, $signed(w_rs1) < $signed(w_aluB)};
      3'd3: w_aluOut = {31'd0, w_rs1 < w_aluB};
      3'd4: w_aluOut = w_rs1 ^ w_aluB;
      3'd5: w_aluOut = w_alt ? $unsigned($signed(w_rs1) >>> w_shamt) : (w_rs1 >> w_shamt);
      3'd6: w_aluOut = w_rs1 | w_aluB;
      default: w_aluOut = w_rs1 & w_aluB;
    endcase
  end

  always_comb begin
    case (w_funct3)
      3'd0:    w_taken = (w_rs1 == w_rs2);
      3'd1:    w_taken = (w_rs1 != w_rs2);
      3'd4:    w_taken = ($signed(w_rs1) < $signed(w_rs2));
      3'd5:    w_taken = ($signed(w_rs1) >= $signed(w_rs2));
      3'd6:    w_taken = (w_rs1 < w_rs2);
      3'd7:    w_taken = (w_rs1 >= w_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_pcPlus4 = r_pc + 32'd4;

  // Unlisted opcodes (FENCE, SYSTEM, custom) fall through as plain pc+4 with no write.
  always_comb begin
    w_target   = w_pcPlus4;
    w_rdData   = w_aluOut;
    w_regWrite = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_rdData   = w_immU;
        w_regWrite = 1'b1;
      end
      OP_AUIPC: begin
        w_rdData   = r_pc + w_immU;
        w_regWrite = 1'b1;
      end
      OP_JAL: begin
        w_rdData   = w_pcPlus4;
        w_regWrite = 1'b1;
        w_target   = r_pc + w_immJ;
      end
      OP_JALR: begin
        w_rdData   = w_pcPlus4;
        w_regWrite = 1'b1;
        w_target   = (w_rs1 + w_immI) & ~32'd1;
      end
      OP_BRANCH: begin
        if (w_taken) w_target = r_pc + w_immB;
      end
      OP_LOAD: begin
        w_rdData   = mem_rdata;
        w_regWrite = 1'b1;
      end
      OP_IMM, OP_REG: begin
        w_regWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_nextPc  = w_target & 32'hFFFF_FFFC;
  assign pc        = r_pc;
  assign mem_addr  = w_rs1 + ((w_opcode == OP_STORE) ? w_immS : w_immI);
  assign mem_wdata = w_rs2;
  assign mem_write = (w_opcode == OP_STORE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC & 32'hFFFF_FFFC;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      r_pc <= w_nextPc;
      if (w_regWrite && w_rd != 5'd0) r_regs[w_rd] <= w_rdData;
    end
  end

endmodule

// File: tb/tb_rv32i_cpu.sv
// Scoreboard bench for rv32i_cpu: directed programs with fixed expectations plus
// random programs checked against an instruction-level reference model.
module tb_rv32i_cpu;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] imem [0:255];
  logic [31:0] ram  [0:32767];
  logic [31:0] mRam [0:32767];
  logic        ramClear;
  logic        monActive;

  logic [31:0] pcQ[$];
  logic [63:0] storeQ[$];
  logic [31:0] expPc;
  logic [63:0] expStore;

  int compared;
  int mismatched;

  rv32i_cpu dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign instr     = imem[pc[9:2]];
  assign mem_rdata = ram[mem_addr[16:2]];

  always @(posedge clk) begin
    if (ramClear) begin
      for (int i = 0; i < 32768; i++) ram[i] <= 32'd0;
    end else if (mem_write) begin
      ram[mem_addr[16:2]] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Instruction encoders, built from field positions with plain integer arithmetic.
  function automatic logic [31:0] encR(int f7, int rs2, int rs1, int f3, int rd, int op);
    return ((f7 & 127) << 25) | ((rs2 & 31) << 20) | ((rs1 & 31) << 15) |
           ((f3 & 7) << 12) | ((rd & 31) << 7) | (op & 127);
  endfunction

  function automatic logic [31:0] encI(int imm, int rs1, int f3, int rd, int op);
    return ((imm & 4095) << 20) | ((rs1 & 31) << 15) | ((f3 & 7) << 12) |
           ((rd & 31) << 7) | (op & 127);
  endfunction

  function automatic logic [31:0] encS(int imm, int rs2, int rs1, int f3);
    return (((imm >> 5) & 127) << 25) | ((rs2 & 31) << 20) | ((rs1 & 31) << 15) |
           ((f3 & 7) << 12) | ((imm & 31) << 7) | 35;
  endfunction

  function automatic logic [31:0] encB(int imm, int rs2, int rs1, int f3);
    return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | ((rs2 & 31) << 20) |
           ((rs1 & 31) << 15) | ((f3 & 7) << 12) | (((imm >> 1) & 15) << 8) |
           (((imm >> 11) & 1) << 7) | 99;
  endfunction

  function automatic logic [31:0] encU(int imm20, int rd, int op);
    return ((imm20 & 1048575) << 12) | ((rd & 31) << 7) | (op & 127);
  endfunction

  function automatic logic [31:0] encJ(int imm, int rd);
    return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20) |
           (((imm >> 12) & 255) << 12) | ((rd & 31) << 7) | 111;
  endfunction

  function automatic logic [31:0] refAlu(int f3, logic [31:0] x, logic [31:0] y, bit alt);
    case (f3)
      0: return alt ? x - y : x + y;
      1: return x << y[4:0];
      2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3: return (x < y) ? 32'd1 : 32'd0;
      4: return x ^ y;
      5: return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
      6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic bit refBranch(int f3, logic [31:0] x, logic [31:0] y);
    case (f3)
      0: return x == y;
      1: return x != y;
      4: return $signed(x) < $signed(y);
      5: return $signed(x) >= $signed(y);
      6: return x < y;
      7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  // Architectural reference: executes the program in imem and records the expected trace.
  task automatic modelRun(input int ncyc);
    logic [31:0] r [32];
    logic [31:0] pcv, ins, a, b, res, nxt, addr;
    logic [31:0] immI, immS, immB, immU, immJ;
    int f3;
    bit wr;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    for (int i = 0; i < 32768; i++) mRam[i] = 32'd0;
    pcv = 32'd0;
    for (int c = 0; c < ncyc; c++) begin
      pcQ.push_back(pcv);
      ins  = imem[pcv[9:2]];
      immI = {{20{ins[31]}}, ins[31:20]};
      immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      immB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      immU = {ins[31:12], 12'd0};
      immJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      a    = r[ins[19:15]];
      b    = r[ins[24:20]];
      f3   = int'(ins[14:12]);
      nxt  = pcv + 32'd4;
      res  = 32'd0;
      wr   = 1'b0;
      case (ins[6:0])
        7'h37: begin res = immU; wr = 1'b1; end
        7'h17: begin res = pcv + immU; wr = 1'b1; end
        7'h6F: begin res = pcv + 32'd4; wr = 1'b1; nxt = pcv + immJ; end
        7'h67: begin res = pcv + 32'd4; wr = 1'b1; nxt = (a + immI) & ~32'd1; end
        7'h63: if (refBranch(f3, a, b)) nxt = pcv + immB;
        7'h03: begin addr = a + immI; res = mRam[addr[16:2]]; wr = 1'b1; end
        7'h23: begin
          addr = a + immS;
          mRam[addr[16:2]] = b;
          storeQ.push_back({addr, b});
        end
        7'h13: begin res = refAlu(f3, a, immI, (f3 == 5) && ins[30]); wr = 1'b1; end
        7'h33: begin res = refAlu(f3, a, b, ins[30]); wr = 1'b1; end
        default: ;
      endcase
      if (wr && ins[11:7] != 5'd0) r[ins[11:7]] = res;
      pcv = nxt & 32'hFFFF_FFFC;
    end
  endtask

  task automatic genRandom();
    int idx, kind, f3, rd, rs1, rs2, imm;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    idx = 0;
    while (idx < 180) begin
      kind = $urandom_range(0, 12);
      rd   = $urandom_range(0, 31);
      rs1  = $urandom_range(0, 31);
      rs2  = $urandom_range(0, 31);
      f3   = $urandom_range(0, 7);
      case (kind)
        0, 1, 2: imem[idx] = encR(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0,
                                  rs2, rs1, f3, rd, 51);
        3, 4, 5: begin
          imm = $urandom_range(0, 4095);
          if (f3 == 1) imm = imm & 31;
          if (f3 == 5) imm = (imm & 31) | ($urandom_range(0, 1) == 1 ? 1024 : 0);
          imem[idx] = encI(imm, rs1, f3, rd, 19);
        end
        6: imem[idx] = encU($urandom, rd, $urandom_range(0, 1) == 1 ? 55 : 23);
        7: imem[idx] = encS($urandom_range(64, 200) * 4, rs2, 0, $urandom_range(0, 2));
        8: begin
          f3 = $urandom_range(0, 4);
          if (f3 >= 3) f3++;
          imem[idx] = encI($urandom_range(64, 200) * 4, 0, f3, rd, 3);
        end
        9: begin
          f3 = $urandom_range(0, 5);
          if (f3 >= 2) f3 += 2;
          imem[idx] = encB($urandom_range(2, 3) * 4, rs2, rs1, f3);
        end
        10: imem[idx] = encJ(8, rd);
        11: begin
          rs1 = $urandom_range(1, 31);
          imem[idx] = encU(0, rs1, 23);
          idx++;
          imem[idx] = encI($urandom_range(12, 15), rs1, 0, rd, 103);
        end
        default: begin
          case ($urandom_range(0, 3))
            0: imem[idx] = 32'h0000_000F;
            1: imem[idx] = 32'h0000_0073;
            2: imem[idx] = 32'h0010_0073;
            default: imem[idx] = ($urandom & 32'hFFFF_FF80) | 32'h0000_000B;
          endcase
        end
      endcase
      idx++;
    end
    for (int i = 1; i < 32; i++) begin
      imem[idx] = encS(1024, i, 0, 2);
      idx++;
    end
    imem[idx] = encJ(0, 0);
  endtask

  task automatic loadDirected(input int which);
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    case (which)
      0: begin
        imem[0] = encI(-5, 0, 0, 1, 19);
        imem[1] = encI(3, 0, 0, 2, 19);
        imem[2] = encR(32, 2, 1, 0, 3, 51);
        imem[3] = encR(0, 1, 2, 3, 4, 51);
        imem[4] = encR(32, 2, 1, 5, 5, 51);
        imem[5] = encU(1, 6, 55);
        imem[6] = encS(0, 3, 6, 2);
        imem[7] = encS(0, 4, 6, 2);
        imem[8] = encS(0, 5, 6, 2);
        imem[9] = encJ(0, 0);
        for (int i = 0; i <= 9; i++) pcQ.push_back(32'(i * 4));
        pcQ.push_back(32'h24);
        storeQ.push_back({32'h1000, 32'hFFFF_FFF8});
        storeQ.push_back({32'h1000, 32'h0000_0001});
        storeQ.push_back({32'h1000, 32'hFFFF_FFFF});
      end
      1: begin
        imem[0] = encU(32'h20, 1, 55);
        imem[1] = encI(32'h5A, 0, 0, 2, 19);
        imem[2] = encS(8, 2, 1, 2);
        imem[3] = encI(8, 1, 2, 3, 3);
        imem[4] = encU(1, 4, 55);
        imem[5] = encS(0, 3, 4, 2);
        imem[6] = encJ(0, 0);
        for (int i = 0; i <= 6; i++) pcQ.push_back(32'(i * 4));
        pcQ.push_back(32'h18);
        storeQ.push_back({32'h0002_0008, 32'h0000_005A});
        storeQ.push_back({32'h0000_1000, 32'h0000_005A});
      end
      default: begin
        imem[0]  = encI(-1, 0, 0, 3, 19);
        imem[1]  = encI(1, 0, 0, 2, 19);
        imem[2]  = encI(7, 0, 0, 0, 19);
        imem[3]  = encB(8, 0, 2, 0);
        imem[4]  = encU(1, 1, 23);
        imem[5]  = encB(8, 3, 2, 6);
        imem[6]  = encI(0, 0, 0, 1, 19);
        imem[7]  = encB(8, 2, 2, 0);
        imem[8]  = encI(0, 0, 0, 1, 19);
        imem[9]  = encJ(12, 5);
        imem[10] = encJ(16, 0);
        imem[12] = encI(0, 5, 0, 6, 103);
        imem[14] = encS(0, 0, 1, 2);
        imem[15] = encS(0, 1, 1, 2);
        imem[16] = encS(0, 5, 1, 2);
        imem[17] = encS(0, 6, 1, 2);
        imem[18] = encJ(0, 0);
        pcQ.push_back(32'h00); pcQ.push_back(32'h04); pcQ.push_back(32'h08);
        pcQ.push_back(32'h0C); pcQ.push_back(32'h10); pcQ.push_back(32'h14);
        pcQ.push_back(32'h1C); pcQ.push_back(32'h24); pcQ.push_back(32'h30);
        pcQ.push_back(32'h28); pcQ.push_back(32'h38); pcQ.push_back(32'h3C);
        pcQ.push_back(32'h40); pcQ.push_back(32'h44); pcQ.push_back(32'h48);
        pcQ.push_back(32'h48);
        storeQ.push_back({32'h1010, 32'h0000_0000});
        storeQ.push_back({32'h1010, 32'h0000_1010});
        storeQ.push_back({32'h1010, 32'h0000_0028});
        storeQ.push_back({32'h1010, 32'h0000_0034});
      end
    endcase
  endtask

  // Holds reset with a store at the reset vector, loads a program, then runs it
  // for a fixed cycle budget while the monitor drains the expectation queues.
  task automatic applyStimulus(input int which);
    int ncyc;
    reset    = 1'b1;
    ramClear = 1'b1;
    imem[0]  = 32'h0000_2023;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_pc", pc, 32'd0);
      checkOutput("reset_mem_write", {31'd0, mem_write}, 32'd0);
    end
    ramClear = 1'b0;
    pcQ.delete();
    storeQ.delete();
    if (which < 3) begin
      loadDirected(which);
      ncyc = 20;
    end else begin
      genRandom();
      ncyc = 230;
      modelRun(ncyc);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    monActive = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    monActive = 1'b0;
    checkOutput("pc_trace_left", pcQ.size(), 32'd0);
    checkOutput("store_trace_left", storeQ.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (monActive) begin
      if (pcQ.size() > 0) begin
        expPc = pcQ.pop_front();
        checkOutput("pc", pc, expPc);
      end
      if (mem_write) begin
        if (storeQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_store: got addr 0x%08h data 0x%08h, expected no store",
                   mem_addr, mem_wdata);
        end else begin
          expStore = storeQ.pop_front();
          checkOutput("store_addr", mem_addr, expStore[63:32]);
          checkOutput("store_data", mem_wdata, expStore[31:0]);
        end
      end
    end
  end

  initial begin
    clk        = 1'b0;
    reset      = 1'b1;
    ramClear   = 1'b0;
    monActive  = 1'b0;
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    for (int p = 0; p < 7; p++) begin
      $display("[TB] program %0d", p);
      applyStimulus(p);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
